// File: rtl/dpd_pkg.sv
// Shared types and sizing for the DPD LUT configuration loader.
package dpd_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Default LUT geometry of a production row.
  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam int unsigned DEPTH          = 1 << ADDR_WIDTH_DEF;

endpackage

// File: rtl/dpd_lut_cksum.sv
// Wrapping accumulator with synchronous clear and add-enable.
// Clear has priority so a new load never inherits a stale partial sum.
module dpd_lut_cksum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] sum_q, sum_d;

  // Next sum: clear, add (mod 2^W), or hold.
  always_comb begin
    sum_d = sum_q;
    if (clr_i)     sum_d = '0;
    else if (en_i) sum_d = sum_q + din_i;
  end

  // Sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/dpd_lut_loader.sv
// Configuration-port sequencer for one DPD LUT row: streams a full LUT into
// the selected i-delay LUT, optionally reads it back and compares checksums.
module dpd_lut_loader
  import dpd_pkg::*;
#(
  parameter int I_DELAY_MAX = 8,
  parameter int IDX_WIDTH   = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [IDX_WIDTH-1:0]   lut_idx,
  input  logic                   verify_en,
  input  logic                   abort,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  output logic [ADDR_WIDTH-1:0]  config_addr,
  output logic [DATA_WIDTH-1:0]  config_din,
  input  logic [DATA_WIDTH-1:0]  config_dout,
  output logic [I_DELAY_MAX-1:0] config_lutId,
  output logic                   config_web,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [DATA_WIDTH-1:0]  checksum
);

  state_e                 state_q, state_d;
  // One extra bit so waddr reaching DEPTH marks completion without aliasing to 0.
  logic [ADDR_WIDTH:0]    waddr_q, waddr_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   verify_q, verify_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   web_q, web_d;
  logic                   rdv_q, rdv_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic [I_DELAY_MAX-1:0] lutid_q, lutid_d;

  logic                   hs;
  logic                   idx_ok;
  logic                   sum_clr;
  logic [DATA_WIDTH-1:0]  wsum, rsum;

  // Ready only while words remain; drops once waddr hits DEPTH.
  assign s_ready = (state_q == WRITE) && !waddr_q[ADDR_WIDTH];
  // A word offered alongside abort is dropped.
  assign hs      = s_valid && s_ready && !abort;
  assign idx_ok  = (32'(lut_idx) < 32'(I_DELAY_MAX));

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    idx_d    = idx_q;
    verify_d = verify_q;
    err_d    = err_q;
    done_d   = 1'b0;
    web_d    = 1'b0;
    rdv_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    sum_clr  = 1'b0;
    lutid_d  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (idx_ok) begin
            state_d  = WRITE;
            waddr_d  = '0;
            err_d    = 1'b0;
            idx_d    = lut_idx;
            verify_d = verify_en;
            sum_clr  = 1'b1;
          end else begin
            // Bad index: report immediately, never leave IDLE.
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (hs) begin
          web_d   = 1'b1;
          addr_d  = waddr_q[ADDR_WIDTH-1:0];
          din_d   = s_data;
          waddr_d = waddr_q + 1'b1;
        end else if (waddr_q[ADDR_WIDTH]) begin
          // Final strobe is on the port this cycle; preload the read address.
          addr_d = '0;
          if (verify_q) begin
            state_d = READ;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        // Data for this address returns next cycle.
        rdv_d = 1'b1;
        if (addr_q == {ADDR_WIDTH{1'b1}}) state_d = DRAIN;
        else                              addr_d  = addr_q + 1'b1;
      end
      DRAIN: state_d = CHECK;
      CHECK: begin
        err_d   = (rsum != wsum);
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      web_d = 1'b0;
      rdv_d = 1'b0;
      err_d = 1'b1;
      if (state_q == DONE) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end

    // Select held continuously from WRITE through CHECK for the row's readback mux.
    if (state_d inside {WRITE, READ, DRAIN, CHECK})
      lutid_d = I_DELAY_MAX'(1) << idx_d;
  end

  // State and registered config-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      idx_q    <= '0;
      verify_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      web_q    <= 1'b0;
      rdv_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      lutid_q  <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      idx_q    <= idx_d;
      verify_q <= verify_d;
      err_q    <= err_d;
      done_q   <= done_d;
      web_q    <= web_d;
      rdv_q    <= rdv_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      lutid_q  <= lutid_d;
    end
  end

  // Sum of accepted stream words.
  dpd_lut_cksum #(.W(DATA_WIDTH)) u_wsum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sum_clr),
    .en_i  (hs),
    .din_i (s_data),
    .sum_o (wsum)
  );

  // Sum of read-back words, one cycle behind the address.
  dpd_lut_cksum #(.W(DATA_WIDTH)) u_rsum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sum_clr),
    .en_i  (rdv_q),
    .din_i (config_dout),
    .sum_o (rsum)
  );

  assign config_addr  = addr_q;
  assign config_din   = din_q;
  assign config_lutId = lutid_q;
  assign config_web   = web_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign error        = err_q;
  assign checksum     = wsum;

endmodule
